// File: rtl/branch_fetch_unit.sv
// branch_fetch_unit: owns the PC and NZVC flags, fetches one instruction at a
// time over a req/ack instruction-memory port, and resolves B, BL, B.cond,
// CBZ, CBNZ and BR when the datapath reports completion.
module branch_fetch_unit #(
    parameter int unsigned              ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]        RESET_PC = '0,
    parameter int unsigned              PC_STEP  = 4,
    parameter int unsigned              LINK_REG = 30
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              insn_valid,
    output logic [31:0]       insn,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              ex_done,
    input  logic              flags_we,
    input  logic [3:0]        alu_flags,
    input  logic              rt_is_zero,
    input  logic [ADDR_W-1:0] br_target,
    output logic [3:0]        flags,
    output logic              link_we,
    output logic [4:0]        link_addr,
    output logic [ADDR_W-1:0] link_data
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [3:0]        flags_q;
    logic [31:0]       insn_q;
    logic              link_we_q;
    logic [ADDR_W-1:0] link_data_q;

    logic              is_b, is_bl, is_bcond, is_cbz, is_cbnz, is_br;
    logic              cond_pass;
    logic              rel_taken;
    logic [ADDR_W-1:0] off26, off19, pc_step;

    logic flag_n, flag_z, flag_v, flag_c;
    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_v = flags_q[1];
    assign flag_c = flags_q[0];

    // Decode the held instruction and compute the PC that follows it.
    always_comb begin
        is_b     = (insn_q[31:26] == 6'b000101);
        is_bl    = (insn_q[31:26] == 6'b100101);
        is_bcond = (insn_q[31:24] == 8'b01010100);
        is_cbz   = (insn_q[31:24] == 8'b10110100);
        is_cbnz  = (insn_q[31:24] == 8'b10110101);
        is_br    = (insn_q[31:21] == 11'b11010110000);

        // Extend to full width first, then scale, so the sign reaches the top bit.
        off26   = {{(ADDR_W-26){insn_q[25]}}, insn_q[25:0]} << 2;
        off19   = {{(ADDR_W-19){insn_q[23]}}, insn_q[23:5]} << 2;
        pc_step = pc_q + ADDR_W'(PC_STEP);

        // Conditions use the registered flags, before any same-cycle update.
        cond_pass = 1'b0;
        unique case (insn_q[3:0])
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !flag_c || flag_z;
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase

        rel_taken = (is_bcond && cond_pass) ||
                    (is_cbz   && rt_is_zero) ||
                    (is_cbnz  && !rt_is_zero);

        pc_d = pc_step;
        if (is_br) begin
            pc_d = br_target;
        end else if (is_b || is_bl) begin
            pc_d = pc_q + off26;
        end else if (rel_taken) begin
            pc_d = pc_q + off19;
        end
    end

    // Two-state fetch/execute sequencer with PC, flag and link registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            flags_q     <= '0;
            insn_q      <= '0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            link_we_q <= 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        insn_q  <= imem_data;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (ex_done) begin
                        pc_q <= pc_d;
                        if (flags_we) begin
                            flags_q <= alu_flags;
                        end
                        if (is_bl) begin
                            link_we_q   <= 1'b1;
                            link_data_q <= pc_step;
                        end
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Outputs are forced idle while reset is held, even before the first edge.
    assign imem_req   = reset && (state_q == FETCH);
    assign insn_valid = reset && (state_q == EXEC);
    assign insn       = reset ? insn_q      : '0;
    assign flags      = reset ? flags_q     : '0;
    assign link_we    = reset && link_we_q;
    assign link_data  = reset ? link_data_q : '0;
    assign link_addr  = 5'(LINK_REG);
    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Testbench for branch_fetch_unit: expected fetch addresses are pushed to a
// scoreboard when each instruction completes and popped when the next fetch
// request appears.
module tb_branch_fetch_unit;

    localparam int unsigned AW = 64;

    localparam logic [31:0] NOP      = 32'hD503201F;
    localparam logic [31:0] ADD      = 32'h8B020020;
    localparam logic [31:0] BR_X0    = 32'hD61F0000;
    localparam logic [31:0] B_M4     = 32'h17FFFFFC;
    localparam logic [31:0] BL_P10   = 32'h94000010;
    localparam logic [31:0] BC_P2    = 32'h54000040;
    localparam logic [31:0] BC_M1    = 32'h54FFFFE0;
    localparam logic [31:0] CBZ_P4   = 32'hB4000080;
    localparam logic [31:0] CBNZ_P4  = 32'hB5000080;

    logic          clock = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_data;
    logic          insn_valid;
    logic [31:0]   insn;
    logic [AW-1:0] pc_out;
    logic          ex_done;
    logic          flags_we;
    logic [3:0]    alu_flags;
    logic          rt_is_zero;
    logic [AW-1:0] br_target;
    logic [3:0]    flags;
    logic          link_we;
    logic [4:0]    link_addr;
    logic [AW-1:0] link_data;

    branch_fetch_unit #(
        .ADDR_W   (AW),
        .RESET_PC ('0),
        .PC_STEP  (4),
        .LINK_REG (30)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .insn_valid (insn_valid),
        .insn       (insn),
        .pc_out     (pc_out),
        .ex_done    (ex_done),
        .flags_we   (flags_we),
        .alu_flags  (alu_flags),
        .rt_is_zero (rt_is_zero),
        .br_target  (br_target),
        .flags      (flags),
        .link_we    (link_we),
        .link_addr  (link_addr),
        .link_data  (link_data)
    );

    always #5 clock = ~clock;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] m_pc;
    logic [3:0]    m_flags;
    logic [31:0]   m_insn;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [AW-1:0] model_next(input logic [31:0] w, input logic [AW-1:0] pc,
                                                 input logic [3:0] f, input logic rz,
                                                 input logic [AW-1:0] tgt);
        logic signed [25:0]   i26;
        logic signed [18:0]   i19;
        logic signed [AW-1:0] e26, e19;
        i26 = w[25:0];
        i19 = w[23:5];
        e26 = i26;
        e19 = i19;
        if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) return pc + e26 * 4;
        if (w[31:24] == 8'h54) return cond_holds(w[3:0], f) ? pc + e19 * 4 : pc + 4;
        if (w[31:24] == 8'hB4) return rz ? pc + e19 * 4 : pc + 4;
        if (w[31:24] == 8'hB5) return !rz ? pc + e19 * 4 : pc + 4;
        if (w[31:21] == 11'b11010110000) return tgt;
        return pc + 4;
    endfunction

    // Wait for a request, check it against the scoreboard, optionally stall, then ack.
    task automatic do_fetch(input logic [31:0] word, input int waits);
        logic [AW-1:0] exp;
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("imem_req", imem_req, 1);
        check_eq("sb_depth", exp_addr_q.size(), 1);
        exp = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : '0;
        check_eq("imem_addr", imem_addr, exp);
        check_eq("insn_valid_fetch", insn_valid, 0);
        for (int i = 0; i < waits; i++) begin
            ex_done   = 1'b1;
            imem_data = 32'hDEADBEEF;
            @(negedge clock);
            ex_done   = 1'b0;
            check_eq("addr_hold", imem_addr, exp);
            check_eq("req_hold", imem_req, 1);
            check_eq("link_we_wait", link_we, 0);
        end
        imem_ack  = 1'b1;
        imem_data = word;
        @(negedge clock);
        imem_ack  = 1'b0;
        imem_data = '0;
        check_eq("insn_valid", insn_valid, 1);
        check_eq("req_in_exec", imem_req, 0);
        check_eq("insn", insn, word);
        check_eq("pc_out", pc_out, exp);
        m_pc   = exp;
        m_insn = word;
    endtask

    // Optionally stall with stray acks, then complete and push the next expected PC.
    task automatic do_exec(input logic fwe, input logic [3:0] af, input logic rz,
                           input logic [AW-1:0] tgt, input int stall);
        logic [AW-1:0] nxt;
        logic          bl;
        for (int i = 0; i < stall; i++) begin
            imem_ack  = 1'b1;
            imem_data = 32'h12345678;
            @(negedge clock);
            imem_ack  = 1'b0;
            check_eq("insn_stable", insn, m_insn);
            check_eq("valid_stable", insn_valid, 1);
        end
        nxt = model_next(m_insn, m_pc, m_flags, rz, tgt);
        bl  = (m_insn[31:26] == 6'b100101);
        ex_done    = 1'b1;
        flags_we   = fwe;
        alu_flags  = af;
        rt_is_zero = rz;
        br_target  = tgt;
        @(negedge clock);
        ex_done    = 1'b0;
        flags_we   = 1'b0;
        alu_flags  = '0;
        rt_is_zero = 1'b0;
        br_target  = '0;
        if (fwe) m_flags = af;
        exp_addr_q.push_back(nxt);
        check_eq("link_we", link_we, bl);
        if (bl) begin
            check_eq("link_addr", link_addr, 30);
            check_eq("link_data", link_data, m_pc + 4);
        end
        check_eq("flags", flags, m_flags);
    endtask

    task automatic step(input logic [31:0] word, input logic fwe, input logic [3:0] af,
                        input logic rz, input logic [AW-1:0] tgt);
        do_fetch(word, 0);
        do_exec(fwe, af, rz, tgt, 0);
    endtask

    task automatic jump(input logic [AW-1:0] addr, input logic fwe, input logic [3:0] af);
        step(BR_X0, fwe, af, 1'b0, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fl_set[2];
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_data  = '0;
        ex_done    = 1'b0;
        flags_we   = 1'b0;
        alu_flags  = '0;
        rt_is_zero = 1'b0;
        br_target  = '0;
        m_flags    = '0;

        repeat (3) @(negedge clock);
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_insn_valid", insn_valid, 0);
        check_eq("rst_insn", insn, 0);
        check_eq("rst_link_we", link_we, 0);
        check_eq("rst_link_data", link_data, 0);
        check_eq("rst_flags", flags, 0);
        check_eq("rst_pc", imem_addr, 0);
        reset = 1'b1;
        exp_addr_q.push_back('0);

        // Sequential stream at full throughput.
        for (int i = 0; i < 4; i++) step(NOP, 1'b0, 4'h0, 1'b0, '0);

        // Backward B with a slow memory and stray acks during EXEC.
        jump(64'h40, 1'b0, 4'h0);
        do_fetch(B_M4, 3);
        do_exec(1'b0, 4'h0, 1'b0, '0, 2);

        // BL with link writeback and a one-cycle strobe.
        jump(64'h100, 1'b0, 4'h0);
        step(BL_P10, 1'b0, 4'h0, 1'b0, '0);
        do_fetch(NOP, 1);
        do_exec(1'b0, 4'h0, 1'b0, '0, 0);

        // Signed conditions after a flag-setting ADD.
        fl_set[0] = 4'b1000;
        fl_set[1] = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            for (int c = 10; c < 12; c++) begin
                jump(64'h1C, 1'b0, 4'h0);
                step(ADD, 1'b1, fl_set[k], 1'b0, '0);
                step(BC_P2 | 32'(c), 1'b0, 4'h0, 1'b0, '0);
            end
        end

        // Condition sees the old flags even when the branch itself loads new ones.
        jump(64'h80, 1'b1, 4'h0);
        step(BC_P2, 1'b1, 4'b0100, 1'b0, '0);
        step(BC_P2, 1'b0, 4'h0, 1'b0, '0);

        // CBZ / CBNZ in both polarities.
        jump(64'h60, 1'b0, 4'h0);
        step(CBZ_P4, 1'b0, 4'h0, 1'b1, '0);
        jump(64'h60, 1'b0, 4'h0);
        step(CBNZ_P4, 1'b0, 4'h0, 1'b1, '0);
        jump(64'h60, 1'b0, 4'h0);
        step(CBZ_P4, 1'b0, 4'h0, 1'b0, '0);
        jump(64'h60, 1'b0, 4'h0);
        step(CBNZ_P4, 1'b0, 4'h0, 1'b0, '0);

        // Every condition code with random flags and a negative imm19.
        for (int c = 0; c < 16; c++) begin
            jump(64'h200, 1'b1, 4'($urandom_range(0, 15)));
            step(BC_M1 | 32'(c), 1'b0, 4'h0, 1'b0, '0);
        end

        // BR to the top of the address space, then wrap to zero.
        jump(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 4'hF);
        step(NOP, 1'b0, 4'h0, 1'b0, '0);

        // Reset during EXEC with ex_done discards the completion.
        do_fetch(BL_P10, 0);
        reset     = 1'b0;
        ex_done   = 1'b1;
        flags_we  = 1'b1;
        alu_flags = 4'h5;
        @(negedge clock);
        ex_done   = 1'b0;
        flags_we  = 1'b0;
        alu_flags = '0;
        check_eq("mid_rst_req", imem_req, 0);
        check_eq("mid_rst_valid", insn_valid, 0);
        check_eq("mid_rst_link_we", link_we, 0);
        check_eq("mid_rst_flags", flags, 0);
        check_eq("mid_rst_pc", imem_addr, 0);
        check_eq("mid_rst_insn", insn, 0);
        reset   = 1'b1;
        m_flags = '0;
        exp_addr_q.delete();
        exp_addr_q.push_back('0);
        step(NOP, 1'b0, 4'h0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
